cmsdk_fpga_sram_arbiter: RTL and testbench
==========================================

Name: cmsdk_fpga_sram_arbiter

Overview:
- Shares one single-port FPGA SRAM (registered read, one-cycle latency, byte-lane writes) between two requesters: M0 (CPU/AHB bridge) and M1 (camera/DMA writer).
- Grants at most one access per cycle.
- Supports locked bursts, round-robin fairness with a hold limit, and returns read data with a valid strobe to the owning requester.

Parameters:
- AW, 14, SRAM word-address width.
- MAX_HOLD, 16, max consecutive locked grants to one requester while the other is waiting (>=1).

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-high reset.
- M0_REQ  input  1  M0 access request; held until granted.
- M0_WRITE  input  1  1=write, 0=read.
- M0_LOCK  input  1  keep ownership after this access (burst).
- M0_ADDR  input  AW  word address.
- M0_WDATA  input  32  write data.
- M0_BE  input  4  byte enables, writes only.
- M0_GNT  output  1  one-cycle pulse: request accepted this cycle.
- M0_RVALID  output  1  read data valid (cycle after read grant).
- M1_*  same set as M0 for requester 1.
- RDATA  output  32  read data, shared by both requesters, qualified by Mx_RVALID.
- SRAM_ADDR  output  AW  to SRAM ADDR.
- SRAM_WDATA  output  32  to SRAM WDATA.
- SRAM_WREN  output  4  byte-lane write enables.
- SRAM_CS  output  1  write strobe.
- SRAM_RDATA  input  32  from SRAM RDATA.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; last-winner=M1, so M0 wins the first tie; hold counter=0.
- FSM states:
  - IDLE: no owner.
  - OWN0 / OWN1: a requester holds the lock.
- Arbitration is combinational from registered state. Grant in cycle N drives the SRAM_* outputs combinationally in cycle N; Mx_GNT is high in the same cycle.
- Winner selection:
  - IDLE: single requester wins; if both request, the one that is not last-winner wins.
  - OWNx: owner wins if it requests. Exception: the other requester is requesting and hold counter == MAX_HOLD-1; then the other wins and ownership is broken.
  - OWNx with owner not requesting: revert to IDLE rules in the same cycle.
- Transitions:
  - Granted access with Mx_LOCK=1 → OWNx.
  - Granted access with LOCK=0 → IDLE.
  - No grant → IDLE.
- Hold counter: increments on each consecutive grant to the same owner while the other is requesting. Clears on owner change, on IDLE, or when the other requester is idle. Saturates at MAX_HOLD-1.
- Write grant: SRAM_ADDR=Mx_ADDR, SRAM_WDATA=Mx_WDATA, SRAM_WREN=Mx_BE, SRAM_CS=1.
- Read grant: SRAM_ADDR=Mx_ADDR, SRAM_WREN=0, SRAM_CS=0.
- Read return: one-cycle registered tag records the reader. Next cycle, Mx_RVALID=1 and RDATA=SRAM_RDATA. Otherwise RDATA=0 and RVALID=0.
- No grant: SRAM_CS=0, SRAM_WREN=0, SRAM_ADDR holds its last value (registered mux select) to avoid toggling.
- Write with BE=0: granted, no SRAM change.
- Back-to-back reads from alternating requesters: full throughput, one grant per cycle; RVALID tags stay in order.
- Read then write to the same address in the next cycle: read returns old data.
- Reset asserted mid-burst: ownership dropped immediately. Any pending RVALID is lost (requester re-issues).

Optional Feature:
- Macro: SRAM_ARB_STAT_EN.
- Defined: adds output STAT_CONFLICTS [15:0], a saturating count of cycles where both REQ are high and one is denied. Also adds input STAT_CLR, a synchronous clear. Counter resets to 0.
- Undefined: no port, no logic.

Decomposition:
- Package cmsdk_sram_arb_pkg: FSM state enum (IDLE, OWN0, OWN1), requester-id constants, MAX_HOLD default.
- One natural sub-module: cmsdk_sram_arb_pick, a combinational winner selector taking state, last-winner, hold-limit flag and both REQ; returns the grant vector.

Test Plan:
- Reset, then M0 write ADDR=0x10, WDATA=0xDEADBEEF, BE=0xF → M0_GNT same cycle, SRAM_CS=1, WREN=0xF. Then M0 read 0x10 → M0_RVALID next cycle, RDATA=0xDEADBEEF, M1_RVALID=0.
- Both requesters issue unlocked reads for 6 cycles → grants alternate M0,M1,M0…, starting with M0; RVALID follows one cycle later to the matching requester.
- M1 locked burst of 40 writes, M0 requesting throughout, MAX_HOLD=16 → M1 gets 16 grants, M0 gets 1, M1 resumes.
- M0 write BE=0x4, WDATA=0x00AA0000 over existing 0x11223344 → readback 0x11AA3344.
- RST pulse while in OWN1 with a read in flight → outputs 0, no RVALID, next tie granted to M0.
- SRAM_ARB_STAT_EN defined, 5 contended cycles → STAT_CONFLICTS=5; STAT_CLR → 0.

Source files
------------

// File: rtl/cmsdk_sram_arb_pkg.sv
// Shared types and constants for the two-port FPGA SRAM arbiter.
// Optional statistics are enabled with SRAM_ARB_STAT_EN.
package cmsdk_sram_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE = 2'd0;
  localparam arb_state_t OWN0 = 2'd1;
  localparam arb_state_t OWN1 = 2'd2;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  localparam int MAX_HOLD_DEF = 16;

endpackage

// File: rtl/cmsdk_sram_arb_pick.sv
// Combinational winner selector: lock ownership, hold-limit
// break and round-robin tie resolution.
module cmsdk_sram_arb_pick
  import cmsdk_sram_arb_pkg::*;
(
  input  arb_state_t state,
  input  logic       last,
  input  logic       hold_lim,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic       own0;
  logic       own1;
  logic [1:0] idle_gnt;

  assign own0 = (state == OWN0) && req[0];
  assign own1 = (state == OWN1) && req[1];

  always_comb begin
    unique case (req)
      2'b01:   idle_gnt = 2'b01;
      2'b10:   idle_gnt = 2'b10;
      2'b11:   idle_gnt = (last == REQ_M1) ? 2'b01 : 2'b10;
      default: idle_gnt = 2'b00;
    endcase
  end

  // An owner that stops requesting falls back to idle rules.
  always_comb begin
    gnt = idle_gnt;
    unique case (1'b1)
      own0:    gnt = (req[1] && hold_lim) ? 2'b10 : 2'b01;
      own1:    gnt = (req[0] && hold_lim) ? 2'b01 : 2'b10;
      default: ;
    endcase
  end

endmodule

// File: rtl/cmsdk_fpga_sram_arbiter.sv
// Two-requester arbiter for a single-port registered-read SRAM.
// Define SRAM_ARB_STAT_EN to add the contention counter.
module cmsdk_fpga_sram_arbiter
  import cmsdk_sram_arb_pkg::*;
#(
  parameter int AW       = 14,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          M0_REQ,
  input  logic          M0_WRITE,
  input  logic          M0_LOCK,
  input  logic [AW-1:0] M0_ADDR,
  input  logic [31:0]   M0_WDATA,
  input  logic [3:0]    M0_BE,
  output logic          M0_GNT,
  output logic          M0_RVALID,
  input  logic          M1_REQ,
  input  logic          M1_WRITE,
  input  logic          M1_LOCK,
  input  logic [AW-1:0] M1_ADDR,
  input  logic [31:0]   M1_WDATA,
  input  logic [3:0]    M1_BE,
  output logic          M1_GNT,
  output logic          M1_RVALID,
  output logic [31:0]   RDATA,
  output logic [AW-1:0] SRAM_ADDR,
  output logic [31:0]   SRAM_WDATA,
  output logic [3:0]    SRAM_WREN,
  output logic          SRAM_CS,
  input  logic [31:0]   SRAM_RDATA
`ifdef SRAM_ARB_STAT_EN
  ,
  input  logic          STAT_CLR,
  output logic [15:0]   STAT_CONFLICTS
`endif
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_TOP = CW'(MAX_HOLD - 1);

  arb_state_t    state_q;
  arb_state_t    state_nx;
  logic [1:0]    req;
  logic [1:0]    gnt;
  logic [1:0]    rtag_q;
  logic          last_q;
  logic          sel_q;
  logic          hold_lim;
  logic          keep;
  logic          wsel;
  logic          wr;
  logic [CW-1:0] hold_q;
  logic [CW-1:0] hold_nx;

  assign req      = {M1_REQ, M0_REQ};
  assign hold_lim = (hold_q == HOLD_TOP);

  cmsdk_sram_arb_pick u_pick (
    .state    (state_q),
    .last     (last_q),
    .hold_lim (hold_lim),
    .req      (req),
    .gnt      (gnt)
  );

  // Idle cycles keep the previous address mux select.
  assign wsel = (|gnt) ? gnt[1] : sel_q;
  assign wr   = (gnt[0] & M0_WRITE) | (gnt[1] & M1_WRITE);

  assign SRAM_ADDR  = wsel ? M1_ADDR : M0_ADDR;
  assign SRAM_WDATA = !wr ? '0 : (gnt[1] ? M1_WDATA : M0_WDATA);
  assign SRAM_WREN  = !wr ? '0 : (gnt[1] ? M1_BE : M0_BE);
  assign SRAM_CS    = wr;

  assign M0_GNT    = gnt[0];
  assign M1_GNT    = gnt[1];
  assign M0_RVALID = rtag_q[0];
  assign M1_RVALID = rtag_q[1];
  assign RDATA     = (|rtag_q) ? SRAM_RDATA : '0;

  always_comb begin
    state_nx = IDLE;
    if (gnt[0] && M0_LOCK)
      state_nx = OWN0;
    else if (gnt[1] && M1_LOCK)
      state_nx = OWN1;
  end

  // Count only owner re-grants that keep the other side waiting.
  assign keep =
    (gnt[0] && (state_q == OWN0) && req[1]) ||
    (gnt[1] && (state_q == OWN1) && req[0]);

  always_comb begin
    hold_nx = '0;
    if (keep)
      hold_nx = hold_lim ? hold_q : hold_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= REQ_M1;
      sel_q   <= 1'b0;
      hold_q  <= '0;
      rtag_q  <= '0;
    end else begin
      state_q <= state_nx;
      hold_q  <= hold_nx;
      rtag_q  <= {gnt[1] & ~M1_WRITE, gnt[0] & ~M0_WRITE};
      if (|gnt) begin
        last_q <= gnt[1];
        sel_q  <= gnt[1];
      end
    end
  end

`ifdef SRAM_ARB_STAT_EN
  logic        conflict;
  logic [15:0] stat_q;

  assign conflict       = (&req) && (gnt != 2'b11);
  assign STAT_CONFLICTS = stat_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      stat_q <= '0;
    else if (STAT_CLR)
      stat_q <= '0;
    else if (conflict && !(&stat_q))
      stat_q <= stat_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cmsdk_fpga_sram_arbiter.sv
// Directed self-checking bench for cmsdk_fpga_sram_arbiter
// with a behavioural registered-read SRAM.
module tb_cmsdk_fpga_sram_arbiter;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_write, m0_lock;
  logic [AW-1:0] m0_addr;
  logic [31:0]   m0_wdata;
  logic [3:0]    m0_be;
  logic          m0_gnt, m0_rvalid;
  logic          m1_req, m1_write, m1_lock;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wdata;
  logic [3:0]    m1_be;
  logic          m1_gnt, m1_rvalid;
  logic [31:0]   rdata;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [3:0]    sram_wren;
  logic          sram_cs;
  logic [31:0]   sram_rdata;
`ifdef SRAM_ARB_STAT_EN
  logic          stat_clr;
  logic [15:0]   stat_conflicts;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmsdk_fpga_sram_arbiter #(.AW(AW), .MAX_HOLD(16)) dut (
    .CLK        (clk),
    .RST        (rst),
    .M0_REQ     (m0_req),
    .M0_WRITE   (m0_write),
    .M0_LOCK    (m0_lock),
    .M0_ADDR    (m0_addr),
    .M0_WDATA   (m0_wdata),
    .M0_BE      (m0_be),
    .M0_GNT     (m0_gnt),
    .M0_RVALID  (m0_rvalid),
    .M1_REQ     (m1_req),
    .M1_WRITE   (m1_write),
    .M1_LOCK    (m1_lock),
    .M1_ADDR    (m1_addr),
    .M1_WDATA   (m1_wdata),
    .M1_BE      (m1_be),
    .M1_GNT     (m1_gnt),
    .M1_RVALID  (m1_rvalid),
    .RDATA      (rdata),
    .SRAM_ADDR  (sram_addr),
    .SRAM_WDATA (sram_wdata),
    .SRAM_WREN  (sram_wren),
    .SRAM_CS    (sram_cs),
    .SRAM_RDATA (sram_rdata)
`ifdef SRAM_ARB_STAT_EN
    ,
    .STAT_CLR       (stat_clr),
    .STAT_CONFLICTS (stat_conflicts)
`endif
  );

  // Read-first SRAM: a same-edge write is not visible to the read.
  logic [31:0] mem [0:255];

  always @(posedge clk) begin
    sram_rdata <= mem[sram_addr[7:0]];
    if (sram_cs)
      for (int b = 0; b < 4; b++)
        if (sram_wren[b])
          mem[sram_addr[7:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
  end

  task automatic m0_drive(input logic req, input logic wr,
                          input logic lk, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    m0_req = req; m0_write = wr; m0_lock = lk;
    m0_addr = a; m0_wdata = d; m0_be = be;
  endtask

  task automatic m1_drive(input logic req, input logic wr,
                          input logic lk, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    m1_req = req; m1_write = wr; m1_lock = lk;
    m1_addr = a; m1_wdata = d; m1_be = be;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_drive(0, 0, 0, '0, '0, '0);
    m1_drive(0, 0, 0, '0, '0, '0);
    @(posedge clk); #3;
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0) begin
      errors++;
      $display("FAIL rst_flags: got %b want 0000",
               {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid});
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_rdata: got %h want 0", rdata);
    end
    checks++;
    if ({sram_addr, sram_wdata, sram_wren, sram_cs} !== '0) begin
      errors++;
      $display("FAIL rst_sram: addr %h wd %h wren %h cs %b want 0",
               sram_addr, sram_wdata, sram_wren, sram_cs);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    m0_drive(1, 1, 0, 'h10, 32'hDEADBEEF, 4'hF);
    #3;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL wr_gnt: got %b want 10", {m0_gnt, m1_gnt});
    end
    checks++;
    if ({sram_cs, sram_wren} !== 5'h1F) begin
      errors++;
      $display("FAIL wr_strobe: cs %b wren %h want 1 f",
               sram_cs, sram_wren);
    end
    checks++;
    if (sram_addr !== 14'h10 || sram_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_bus: addr %h wd %h want 10 deadbeef",
               sram_addr, sram_wdata);
    end
    @(posedge clk); #1;
    m0_drive(1, 0, 0, 'h10, '0, '0);
    #3;
    checks++;
    if (m0_gnt !== 1'b1 || sram_cs !== 1'b0 || sram_wren !== 4'h0) begin
      errors++;
      $display("FAIL rd_gnt: gnt %b cs %b wren %h want 1 0 0",
               m0_gnt, sram_cs, sram_wren);
    end
    @(posedge clk); #1;
    m0_req = 1'b0;
    #3;
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b10) begin
      errors++;
      $display("FAIL rd_valid: got %b want 10", {m0_rvalid, m1_rvalid});
    end
    checks++;
    if (rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_data: got %h want deadbeef", rdata);
    end
    checks++;
    if (sram_addr !== 14'h10 || sram_cs !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: addr %h cs %b want 10 0",
               sram_addr, sram_cs);
    end
  endtask

  task automatic test_alternating();
    logic [1:0]  exp_g;
    logic [1:0]  exp_v;
    logic [31:0] exp_d;
    @(posedge clk); #1;
    m1_drive(1, 1, 0, 'h30, 32'hCAFEF00D, 4'hF);
    #3;
    checks++;
    if (m1_gnt !== 1'b1) begin
      errors++;
      $display("FAIL alt_seed: m1_gnt %b want 1", m1_gnt);
    end
    @(posedge clk); #1;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      if (k < 6) begin
        m0_drive(1, 0, 0, 'h10, '0, '0);
        m1_drive(1, 0, 0, 'h30, '0, '0);
      end else begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      #3;
      if (k < 6) begin
        exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if ({m1_gnt, m0_gnt} !== exp_g) begin
          errors++;
          $display("FAIL alt_gnt[%0d]: got %b want %b",
                   k, {m1_gnt, m0_gnt}, exp_g);
        end
      end
      if (k > 0) begin
        exp_v = ((k - 1) % 2 == 0) ? 2'b01 : 2'b10;
        exp_d = exp_v[0] ? 32'hDEADBEEF : 32'hCAFEF00D;
        checks++;
        if ({m1_rvalid, m0_rvalid} !== exp_v || rdata !== exp_d) begin
          errors++;
          $display("FAIL alt_rv[%0d]: v %b d %h want %b %h",
                   k, {m1_rvalid, m0_rvalid}, rdata, exp_v, exp_d);
        end
      end
    end
  endtask

  task automatic test_hold_limit();
    int   idx = 0;
    int   cyc = 0;
    int   m1_before = 0;
    int   m0_cnt = 0;
    int   m0_cyc = -1;
    logic m0_pend = 1'b1;
    logic dual = 1'b0;
    while (cyc < 80 && idx < 40) begin
      @(posedge clk); #1;
      m1_drive(1, 1, idx != 39, AW'(32'h80 + idx), 32'(idx), 4'hF);
      m0_drive(m0_pend && cyc >= 1, 0, 0, 'h10, '0, '0);
      #3;
      if (m0_gnt && m1_gnt)
        dual = 1'b1;
      if (m1_gnt) begin
        idx++;
        if (m0_cyc < 0)
          m1_before++;
      end
      if (m0_gnt) begin
        m0_cnt++;
        m0_cyc = cyc;
        m0_pend = 1'b0;
      end
      cyc++;
    end
    @(posedge clk); #1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    checks++;
    if (idx !== 40 || cyc !== 41) begin
      errors++;
      $display("FAIL hold_total: writes %0d cycles %0d want 40 41",
               idx, cyc);
    end
    checks++;
    if (m1_before !== 16 || m0_cyc !== 16) begin
      errors++;
      $display("FAIL hold_break: m1 %0d at %0d want 16 16",
               m1_before, m0_cyc);
    end
    checks++;
    if (m0_cnt !== 1 || dual !== 1'b0) begin
      errors++;
      $display("FAIL hold_m0: grants %0d dual %b want 1 0",
               m0_cnt, dual);
    end
  endtask

  task automatic test_byte_enable();
    @(posedge clk); #1;
    m0_drive(1, 1, 0, 'h40, 32'h11223344, 4'hF);
    #3;
    checks++;
    if (m0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL be_init: gnt %b want 1", m0_gnt);
    end
    @(posedge clk); #1;
    m0_drive(1, 1, 0, 'h40, 32'h00AA0000, 4'h4);
    #3;
    checks++;
    if (sram_wren !== 4'h4 || sram_wdata !== 32'h00AA0000) begin
      errors++;
      $display("FAIL be_lane: wren %h wd %h want 4 00aa0000",
               sram_wren, sram_wdata);
    end
    @(posedge clk); #1;
    m0_drive(1, 1, 0, 'h40, 32'hFFFFFFFF, 4'h0);
    #3;
    checks++;
    if ({m0_gnt, sram_cs, sram_wren} !== 6'b110000) begin
      errors++;
      $display("FAIL be_zero: gnt %b cs %b wren %h want 1 1 0",
               m0_gnt, sram_cs, sram_wren);
    end
    @(posedge clk); #1;
    m0_drive(1, 0, 0, 'h40, '0, '0);
    #3;
    @(posedge clk); #1;
    m0_req = 1'b0;
    m1_drive(1, 1, 0, 'h40, 32'h55555555, 4'hF);
    #3;
    checks++;
    if (m1_gnt !== 1'b1 || m0_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rw_flags: m1_gnt %b m0_rv %b want 1 1",
               m1_gnt, m0_rvalid);
    end
    checks++;
    if (rdata !== 32'h11AA3344) begin
      errors++;
      $display("FAIL rw_old: got %h want 11aa3344", rdata);
    end
    @(posedge clk); #1;
    m1_req = 1'b0;
    m0_drive(1, 0, 0, 'h40, '0, '0);
    @(posedge clk); #1;
    m0_req = 1'b0;
    #3;
    checks++;
    if (rdata !== 32'h55555555) begin
      errors++;
      $display("FAIL rw_new: got %h want 55555555", rdata);
    end
  endtask

  task automatic test_reset_mid_burst();
    @(posedge clk); #1;
    m1_drive(1, 0, 1, 'h30, '0, '0);
    #3;
    checks++;
    if (m1_gnt !== 1'b1) begin
      errors++;
      $display("FAIL mid_lock: m1_gnt %b want 1", m1_gnt);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    m1_req = 1'b0;
    m0_drive(0, 0, 0, '0, '0, '0);
    #2;
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0) begin
      errors++;
      $display("FAIL mid_flags: got %b want 0000",
               {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid});
    end
    checks++;
    if (rdata !== 32'h0 || sram_addr !== '0 || sram_cs !== 1'b0) begin
      errors++;
      $display("FAIL mid_bus: rd %h addr %h cs %b want 0 0 0",
               rdata, sram_addr, sram_cs);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    m0_drive(1, 0, 0, 'h10, '0, '0);
    m1_drive(1, 0, 1, 'h30, '0, '0);
    #3;
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL mid_tie: got %b want 01", {m1_gnt, m0_gnt});
    end
    @(posedge clk); #1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    #3;
    checks++;
    if ({m1_rvalid, m0_rvalid} !== 2'b01) begin
      errors++;
      $display("FAIL mid_rv: got %b want 01", {m1_rvalid, m0_rvalid});
    end
  endtask

`ifdef SRAM_ARB_STAT_EN
  task automatic test_stats();
    @(posedge clk); #1;
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      m0_drive(1, 0, 0, 'h10, '0, '0);
      m1_drive(1, 0, 0, 'h30, '0, '0);
    end
    @(posedge clk); #1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    #3;
    checks++;
    if (stat_conflicts !== 16'd5) begin
      errors++;
      $display("FAIL stat_cnt: got %0d want 5", stat_conflicts);
    end
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    #3;
    checks++;
    if (stat_conflicts !== 16'd0) begin
      errors++;
      $display("FAIL stat_clr: got %0d want 0", stat_conflicts);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, want summary");
    $fatal(1);
  end

  initial begin
`ifdef SRAM_ARB_STAT_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_write_read();
    test_alternating();
    test_hold_limit();
    test_byte_enable();
    test_reset_mid_burst();
`ifdef SRAM_ARB_STAT_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
